// File: rtl/prim_clock_gating_ctrl.sv
// Multi-channel clock-gate controller: a per-channel OFF/WAKE/ON/HOLD FSM
// drives one glitch-free clock-gate cell per channel.

module prim_clock_gating #(
  parameter int Impl = 0
) (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_hold;

  generate
    if (Impl == 0) begin : g_generic
      // Transparent-low latch keeps the enable stable while clk_i is high.
      always_latch begin
        if (!clk_i) begin
          en_hold = en_i | test_en_i;
        end
      end
    end else begin : g_xilinx
      // Falling-edge capture, equivalent to a BUFGCE-style synchronous enable.
      always_ff @(negedge clk_i) begin
        en_hold <= en_i | test_en_i;
      end
    end
  endgenerate

  assign clk_o = clk_i & en_hold;

endmodule

module prim_clock_gating_ctrl #(
  parameter int NumCh      = 4,
  parameter int WakeCycles = 2,
  parameter int HoldCycles = 8,
  parameter int Impl       = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_en_i,
  input  logic [NumCh-1:0] req_i,
  input  logic [NumCh-1:0] force_on_i,
  output logic [NumCh-1:0] clk_o,
  output logic [NumCh-1:0] en_o,
  output logic [NumCh-1:0] ack_o,
  output logic             all_off_o
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [7:0] WakeInit = (WakeCycles > 0) ? 8'(WakeCycles - 1) : 8'd0;
  localparam logic [7:0] HoldInit = (HoldCycles > 0) ? 8'(HoldCycles - 1) : 8'd0;
  localparam logic       HasWake  = (WakeCycles > 0);
  localparam logic       HasHold  = (HoldCycles > 0);

  logic [NumCh-1:0] want;
  logic [NumCh-1:0] next_off;
  logic             all_off_q;

  assign want = req_i | force_on_i;

  genvar i;
  generate
    for (i = 0; i < NumCh; i++) begin : g_ch
      state_e     state;
      state_e     next_state;
      logic [7:0] cnt;
      logic [7:0] next_cnt;
      logic       next_en;
      logic       next_ack;
      logic       en_q;
      logic       ack_q;

      // State, counter and output registers; outputs follow next_state so
      // they change on the same edge as the state they describe.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state <= OFF;
          cnt   <= 8'd0;
          en_q  <= 1'b0;
          ack_q <= 1'b0;
        end else begin
          state <= next_state;
          cnt   <= next_cnt;
          en_q  <= next_en;
          ack_q <= next_ack;
        end
      end

      // Next-state logic; WAKE ignores want so a started wake always completes.
      always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
          OFF: begin
            if (want[i]) begin
              if (HasWake) begin
                next_state = WAKE;
                next_cnt   = WakeInit;
              end else begin
                next_state = ON;
                next_cnt   = 8'd0;
              end
            end else begin
              next_state = OFF;
              next_cnt   = 8'd0;
            end
          end
          WAKE: begin
            if (cnt == 8'd0) begin
              next_state = ON;
            end else begin
              next_cnt = cnt - 8'd1;
            end
          end
          ON: begin
            if (!want[i]) begin
              if (HasHold) begin
                next_state = HOLD;
                next_cnt   = HoldInit;
              end else begin
                next_state = OFF;
                next_cnt   = 8'd0;
              end
            end else begin
              next_state = ON;
            end
          end
          HOLD: begin
            if (want[i]) begin
              next_state = ON;
              next_cnt   = 8'd0;
            end else if (cnt == 8'd0) begin
              next_state = OFF;
            end else begin
              next_cnt = cnt - 8'd1;
            end
          end
          default: begin
            next_state = OFF;
            next_cnt   = 8'd0;
          end
        endcase
      end

      // Output decode of the state about to be entered.
      always_comb begin
        next_en  = 1'b0;
        next_ack = 1'b0;
        case (next_state)
          OFF: begin
            next_en  = 1'b0;
            next_ack = 1'b0;
          end
          WAKE: begin
            next_en  = 1'b1;
            next_ack = 1'b0;
          end
          ON, HOLD: begin
            next_en  = 1'b1;
            next_ack = 1'b1;
          end
          default: begin
            next_en  = 1'b0;
            next_ack = 1'b0;
          end
        endcase
      end

      assign next_off[i] = (next_state == OFF);
      assign en_o[i]     = en_q;
      assign ack_o[i]    = ack_q;

      prim_clock_gating #(
        .Impl (Impl)
      ) u_gate (
        .clk_i     (clk_i),
        .en_i      (en_q),
        .test_en_i (test_en_i),
        .clk_o     (clk_o[i])
      );
    end
  endgenerate

  // Registered summary of every channel being gated off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      all_off_q <= 1'b1;
    end else begin
      all_off_q <= &next_off;
    end
  end

  assign all_off_o = all_off_q;

endmodule

// File: tb/tb_prim_clock_gating_ctrl.sv
// Bench for prim_clock_gating_ctrl: a default instance (Wake 2, Hold 8) and a
// zero-delay instance, both compared against a time-stamp reference model.

module tb_prim_clock_gating_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       test_en;
  logic [3:0] req;
  logic [3:0] force_on;

  logic [3:0] clk_o_a, en_a, ack_a;
  logic       all_off_a;
  logic [3:0] clk_o_b, en_b, ack_b;
  logic       all_off_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int  wake_c[2] = '{2, 0};
  int  hold_c[2] = '{8, 0};
  bit  act[2][4];
  int  ack_t[2][4];
  int  last_h[2][4];
  bit  prev_valid = 1'b0;
  logic [3:0] prev_en[2];

  always #5 clk = ~clk;

  prim_clock_gating_ctrl #(.NumCh(4), .WakeCycles(2), .HoldCycles(8), .Impl(1)) u_dut (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .req_i(req), .force_on_i(force_on),
    .clk_o(clk_o_a), .en_o(en_a), .ack_o(ack_a), .all_off_o(all_off_a)
  );

  prim_clock_gating_ctrl #(.NumCh(4), .WakeCycles(0), .HoldCycles(0), .Impl(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en), .req_i(req), .force_on_i(force_on),
    .clk_o(clk_o_b), .en_o(en_b), .ack_o(ack_b), .all_off_o(all_off_b)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Channel is active from the request edge; ack comes Wake edges later; once
  // acknowledged it drops after Hold+1 consecutive edges without want.
  task automatic model_edge(input int k);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        bit w;
        w = req[c] | force_on[c];
        if (rst) begin
          act[d][c] = 1'b0;
        end else if (!act[d][c]) begin
          if (w) begin
            act[d][c]    = 1'b1;
            ack_t[d][c]  = k + wake_c[d];
            last_h[d][c] = k + wake_c[d];
          end
        end else if (k > ack_t[d][c]) begin
          if (w) last_h[d][c] = k;
          else if (k - last_h[d][c] >= hold_c[d] + 1) act[d][c] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_en(input int d);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = act[d][c];
    return v;
  endfunction

  function automatic logic [3:0] exp_ack(input int d, input int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = act[d][c] && (k >= ack_t[d][c]);
    return v;
  endfunction

  // One clock: advance model, then check all outputs 1 time unit after the edge.
  task automatic step();
    logic [3:0] gate_a, gate_b;
    gate_a = prev_en[0] | {4{test_en}};
    gate_b = prev_en[1] | {4{test_en}};
    @(posedge clk);
    cyc++;
    model_edge(cyc);
    #1;
    if (prev_valid) begin
      check("clk_o_a", clk_o_a, gate_a);
      check("clk_o_b", clk_o_b, gate_b);
    end
    check("en_a",  en_a,  exp_en(0));
    check("ack_a", ack_a, exp_ack(0, cyc));
    check("all_off_a", {3'b000, all_off_a}, {3'b000, exp_en(0) == 4'h0});
    check("en_b",  en_b,  exp_en(1));
    check("ack_b", ack_b, exp_ack(1, cyc));
    check("all_off_b", {3'b000, all_off_b}, {3'b000, exp_en(1) == 4'h0});
    prev_en[0] = exp_en(0);
    prev_en[1] = exp_en(1);
    prev_valid = 1'b1;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; req = 4'hF; force_on = 4'h0;
    for (int d = 0; d < 2; d++) prev_en[d] = 4'h0;
    // Reset held with all requests up, then release.
    run(3);
    rst = 1'b0;
    run(5);
    req = 4'h0;
    run(12);
    // 5-cycle pulse on channel 0.
    req[0] = 1'b1; run(5);
    req[0] = 1'b0; run(16);
    // Re-request during HOLD, then re-request on the expiry edge.
    req[1] = 1'b1; run(5);
    req[1] = 1'b0; run(4);
    req[1] = 1'b1; run(3);
    req[1] = 1'b0; run(8);
    req[1] = 1'b1; run(3);
    req[1] = 1'b0; run(14);
    // One-cycle pulse during WAKE still completes.
    req[2] = 1'b1; run(1);
    req[2] = 1'b0; run(15);
    // force_on keeps the channel on; test_en opens gates with all channels OFF.
    force_on[3] = 1'b1; run(20);
    force_on[3] = 1'b0; run(14);
    test_en = 1'b1; run(4);
    test_en = 1'b0; run(2);
    // Reset in the middle of HOLD.
    req = 4'hF; run(5);
    req = 4'h0; run(3);
    rst = 1'b1; run(1);
    rst = 1'b0; run(3);
    // Randomized traffic.
    for (int j = 0; j < 600; j++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 5) == 0) req[c] = ~req[c];
      end
      if ($urandom_range(0, 40) == 0) force_on = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 30) == 0) test_en = ~test_en;
      rst = ($urandom_range(0, 80) == 0);
      step();
    end
    rst = 1'b0; req = 4'h0; force_on = 4'h0; test_en = 1'b0;
    run(12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
